// File: rtl/scope_capture_ctrl_pkg.sv
// Shared types for the scope acquisition sequencer: FSM states and default widths.
// Same encodings the ADC controller and readout block agree on.
package scope_capture_ctrl_pkg;

    localparam int DATA_W_DEF  = 14;
    localparam int ADDR_W_DEF  = 10;
    localparam int DECIM_W_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FILL      = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_POST      = 3'd3,
        ST_DONE      = 3'd4
    } state_e;

    function automatic logic is_busy(input state_e s);
        return (s == ST_FILL) || (s == ST_WAIT_TRIG) || (s == ST_POST);
    endfunction

endpackage

// File: rtl/scope_capture_ctrl_trig_detect.sv
// Level/edge trigger detector over the stream of kept samples.
// Holds the previous kept sample; hit is combinational on the current kept sample.
module scope_capture_ctrl_trig_detect #(
    parameter int DATA_W = 14
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     keep,
    input  logic signed [DATA_W-1:0] sample,
    input  logic signed [DATA_W-1:0] level,
    input  logic                     rising,
    output logic                     hit
);

    logic signed [DATA_W-1:0] prev_q, prev_d;
    logic                     have_prev_q, have_prev_d;

    always_comb begin
        prev_d      = prev_q;
        have_prev_d = have_prev_q;
        if (clear) begin
            have_prev_d = 1'b0;
        end else if (keep) begin
            prev_d      = sample;
            have_prev_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q      <= '0;
            have_prev_q <= 1'b0;
        end else begin
            prev_q      <= prev_d;
            have_prev_q <= have_prev_d;
        end
    end

    assign hit = keep && have_prev_q &&
                 (rising ? ((prev_q <  level) && (sample >= level))
                         : ((prev_q >= level) && (sample <  level)));

endmodule

// File: rtl/scope_capture_ctrl.sv
// One-shot oscilloscope acquisition: decimate, pre-trigger fill, trigger, post-trigger fill
// into an external circular RAM; reports record start and trigger addresses.
module scope_capture_ctrl
    import scope_capture_ctrl_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DECIM_W = DECIM_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sample_valid,
    input  logic signed [DATA_W-1:0] sample,
    input  logic                     arm,
    input  logic                     abort,
    input  logic signed [DATA_W-1:0] trig_level,
    input  logic                     trig_rising,
    input  logic                     trig_force,
    input  logic [ADDR_W-1:0]        pretrig,
    input  logic [DECIM_W-1:0]       decim,
    output logic                     buf_we,
    output logic [ADDR_W-1:0]        buf_waddr,
    output logic [DATA_W-1:0]        buf_wdata,
    output logic [ADDR_W-1:0]        start_addr,
    output logic [ADDR_W-1:0]        trig_addr,
    output logic                     busy,
    output logic                     triggered,
    output logic                     done
);

    state_e                   state_q, state_d;
    logic [ADDR_W-1:0]        waddr_q, waddr_d;
    logic [ADDR_W-1:0]        fill_cnt_q, fill_cnt_d;
    logic [ADDR_W-1:0]        post_cnt_q, post_cnt_d;
    logic [ADDR_W-1:0]        pretrig_q, pretrig_d;
    logic [DECIM_W-1:0]       dec_cnt_q, dec_cnt_d;
    logic [DECIM_W-1:0]       decim_q, decim_d;
    logic signed [DATA_W-1:0] level_q, level_d;
    logic                     rising_q, rising_d;
    logic                     force_pend_q, force_pend_d;
    logic                     buf_we_q, buf_we_d;
    logic [ADDR_W-1:0]        buf_waddr_q, buf_waddr_d;
    logic [DATA_W-1:0]        buf_wdata_q, buf_wdata_d;
    logic [ADDR_W-1:0]        start_addr_q, start_addr_d;
    logic [ADDR_W-1:0]        trig_addr_q, trig_addr_d;
    logic                     busy_q, busy_d;
    logic                     triggered_q, triggered_d;
    logic                     done_q, done_d;

    logic valid_busy, keep, arm_acc, hit;

    assign arm_acc    = arm && !abort && !is_busy(state_q);
    assign valid_busy = sample_valid && is_busy(state_q) && !abort;
    assign keep       = valid_busy && (dec_cnt_q == '0);

    scope_capture_ctrl_trig_detect #(.DATA_W(DATA_W)) u_trig (
        .clk    (clk),
        .rst    (rst),
        .clear  (arm_acc),
        .keep   (keep),
        .sample (sample),
        .level  (level_q),
        .rising (rising_q),
        .hit    (hit)
    );

    always_comb begin
        state_d      = state_q;
        waddr_d      = waddr_q;
        fill_cnt_d   = fill_cnt_q;
        post_cnt_d   = post_cnt_q;
        pretrig_d    = pretrig_q;
        dec_cnt_d    = dec_cnt_q;
        decim_d      = decim_q;
        level_d      = level_q;
        rising_d     = rising_q;
        force_pend_d = force_pend_q;
        buf_waddr_d  = buf_waddr_q;
        buf_wdata_d  = buf_wdata_q;
        start_addr_d = start_addr_q;
        trig_addr_d  = trig_addr_q;
        triggered_d  = triggered_q;
        buf_we_d     = keep;

        if (valid_busy)
            dec_cnt_d = keep ? decim_q : dec_cnt_q - DECIM_W'(1);

        if (keep) begin
            buf_waddr_d = waddr_q;
            buf_wdata_d = sample;
            waddr_d     = waddr_q + ADDR_W'(1);
        end

        case (state_q)
            ST_FILL: begin
                if (keep) begin
                    fill_cnt_d = fill_cnt_q + ADDR_W'(1);
                    if (fill_cnt_q + ADDR_W'(1) == pretrig_q)
                        state_d = ST_WAIT_TRIG;
                end
            end
            ST_WAIT_TRIG: begin
                force_pend_d = force_pend_q | trig_force;
                if (keep && (hit || force_pend_q || trig_force)) begin
                    trig_addr_d  = waddr_q;
                    start_addr_d = waddr_q - pretrig_q;
                    triggered_d  = 1'b1;
                    force_pend_d = 1'b0;
                    // DEPTH-1-pretrig is the bitwise complement in ADDR_W bits
                    post_cnt_d   = ~pretrig_q;
                    state_d      = (~pretrig_q == '0) ? ST_DONE : ST_POST;
                end
            end
            ST_POST: begin
                if (keep) begin
                    post_cnt_d = post_cnt_q - ADDR_W'(1);
                    if (post_cnt_q == ADDR_W'(1))
                        state_d = ST_DONE;
                end
            end
            default: ;
        endcase

        // The ADDR_W-wide pretrig port already caps the value at DEPTH-1.
        if (arm_acc) begin
            level_d      = trig_level;
            rising_d     = trig_rising;
            decim_d      = decim;
            pretrig_d    = pretrig;
            waddr_d      = '0;
            dec_cnt_d    = '0;
            fill_cnt_d   = '0;
            force_pend_d = 1'b0;
            triggered_d  = 1'b0;
            state_d      = (pretrig == '0) ? ST_WAIT_TRIG : ST_FILL;
        end

        if (abort) begin
            state_d      = ST_IDLE;
            triggered_d  = 1'b0;
            force_pend_d = 1'b0;
        end

        busy_d = is_busy(state_d);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            waddr_q      <= '0;
            fill_cnt_q   <= '0;
            post_cnt_q   <= '0;
            pretrig_q    <= '0;
            dec_cnt_q    <= '0;
            decim_q      <= '0;
            level_q      <= '0;
            rising_q     <= 1'b0;
            force_pend_q <= 1'b0;
            buf_we_q     <= 1'b0;
            buf_waddr_q  <= '0;
            buf_wdata_q  <= '0;
            start_addr_q <= '0;
            trig_addr_q  <= '0;
            busy_q       <= 1'b0;
            triggered_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            waddr_q      <= waddr_d;
            fill_cnt_q   <= fill_cnt_d;
            post_cnt_q   <= post_cnt_d;
            pretrig_q    <= pretrig_d;
            dec_cnt_q    <= dec_cnt_d;
            decim_q      <= decim_d;
            level_q      <= level_d;
            rising_q     <= rising_d;
            force_pend_q <= force_pend_d;
            buf_we_q     <= buf_we_d;
            buf_waddr_q  <= buf_waddr_d;
            buf_wdata_q  <= buf_wdata_d;
            start_addr_q <= start_addr_d;
            trig_addr_q  <= trig_addr_d;
            busy_q       <= busy_d;
            triggered_q  <= triggered_d;
            done_q       <= done_d;
        end
    end

    assign buf_we     = buf_we_q;
    assign buf_waddr  = buf_waddr_q;
    assign buf_wdata  = buf_wdata_q;
    assign start_addr = start_addr_q;
    assign trig_addr  = trig_addr_q;
    assign busy       = busy_q;
    assign triggered  = triggered_q;
    assign done       = done_q;

endmodule

// File: tb/tb_scope_capture_ctrl.sv
// Directed bench for scope_capture_ctrl with a 16-deep buffer; a small reference model
// pushes expected RAM writes into a scoreboard queue that is drained as buf_we appears.
module tb_scope_capture_ctrl;

    localparam int DW  = 14;
    localparam int AW  = 4;
    localparam int DCW = 16;
    localparam int DEP = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 sample_valid, arm, abort, trig_rising, trig_force;
    logic signed [DW-1:0] sample, trig_level;
    logic [AW-1:0]        pretrig;
    logic [DCW-1:0]       decim;
    logic                 buf_we, busy, triggered, done;
    logic [AW-1:0]        buf_waddr, start_addr, trig_addr;
    logic signed [DW-1:0] buf_wdata;

    scope_capture_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DECIM_W(DCW)) dut (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample(sample),
        .arm(arm), .abort(abort), .trig_level(trig_level), .trig_rising(trig_rising),
        .trig_force(trig_force), .pretrig(pretrig), .decim(decim),
        .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
        .start_addr(start_addr), .trig_addr(trig_addr), .busy(busy),
        .triggered(triggered), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct { int addr; int data; } wr_t;
    typedef enum int {M_IDLE, M_FILL, M_WAIT, M_POST, M_DONE} mst_e;

    wr_t  sb[$];
    int   n_cmp = 0, n_err = 0, n_we = 0;
    int   mem [DEP];
    mst_e m_st = M_IDLE;
    int   m_waddr, m_dec, m_fill, m_post, m_pre, m_decim, m_level, m_prev;
    bit   m_rising, m_have, m_force;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_busy();
        return (m_st == M_FILL) || (m_st == M_WAIT) || (m_st == M_POST);
    endfunction

    // Reference model step for one valid sample; returns whether it should be written.
    function automatic bit m_sample(input int s, input bit frc);
        bit k = 0, h;
        wr_t w;
        if (m_busy()) begin
            if (m_dec == 0) begin k = 1; m_dec = m_decim; end
            else m_dec--;
        end
        if (m_st == M_WAIT && frc) m_force = 1;
        if (!k) return 0;
        w.addr = m_waddr; w.data = s;
        sb.push_back(w);
        h = m_have && (m_rising ? (m_prev < m_level && s >= m_level)
                                : (m_prev >= m_level && s < m_level));
        m_prev = s; m_have = 1;
        case (m_st)
            M_FILL: begin m_fill++; if (m_fill == m_pre) m_st = M_WAIT; end
            M_WAIT: if (h || m_force) begin
                m_force = 0;
                m_post  = DEP - 1 - m_pre;
                m_st    = (m_post == 0) ? M_DONE : M_POST;
            end
            M_POST: begin m_post--; if (m_post == 0) m_st = M_DONE; end
            default: ;
        endcase
        m_waddr = (m_waddr + 1) % DEP;
        return 1;
    endfunction

    // Inputs change on the falling edge; outputs are checked on the next falling edge.
    task automatic send(input int s, input bit frc = 0);
        bit  ek;
        wr_t w;
        ek = rst ? 1'b0 : m_sample(s, frc);
        sample = s[DW-1:0]; sample_valid = 1; trig_force = frc;
        @(posedge clk);
        @(negedge clk);
        sample_valid = 0; trig_force = 0;
        chk("buf_we", {31'b0, buf_we}, {31'b0, ek});
        if (buf_we === 1'b1) begin
            n_we++;
            mem[buf_waddr] = int'(buf_wdata);
            if (sb.size() > 0) begin
                w = sb.pop_front();
                chk("buf_waddr", {28'b0, buf_waddr}, w.addr);
                chk("buf_wdata", {18'b0, buf_wdata}, w.data & 'h3fff);
            end
        end
    endtask

    task automatic do_arm();
        if (!m_busy()) begin
            m_st = (pretrig == 0) ? M_WAIT : M_FILL;
            m_pre = int'(pretrig); m_decim = int'(decim); m_level = int'(trig_level);
            m_rising = trig_rising; m_waddr = 0; m_dec = 0; m_fill = 0;
            m_have = 0; m_force = 0;
        end
        arm = 1; @(posedge clk); @(negedge clk); arm = 0;
    endtask

    task automatic do_abort();
        m_st = M_IDLE; m_force = 0;
        abort = 1; @(posedge clk); @(negedge clk); abort = 0;
    endtask

    task automatic force_only();
        if (m_st == M_WAIT) m_force = 1;
        trig_force = 1; @(posedge clk); @(negedge clk); trig_force = 0;
    endtask

    task automatic cfg(input int d, input int p, input bit r, input int lv);
        decim = d[DCW-1:0]; pretrig = p[AW-1:0]; trig_rising = r; trig_level = lv[DW-1:0];
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_outs"}, {24'b0, buf_we, busy, triggered, done, buf_waddr},  32'h0);
        chk({tag, "_addrs"}, {24'b0, start_addr, trig_addr}, 32'h0);
        chk({tag, "_wdata"}, {18'b0, buf_wdata}, 32'h0);
    endtask

    initial begin
        rst = 1; sample_valid = 0; sample = '0; arm = 0; abort = 0; trig_force = 0;
        cfg(0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk_outs_zero("reset");
        rst = 0;
        @(negedge clk);

        // 1: ramp through level 0, rising, pretrig 4
        cfg(0, 4, 1, 0);
        do_arm();
        chk("t1_busy", {31'b0, busy}, 1);
        n_we = 0;
        for (int v = -8; v <= 11; v++) send(v);
        chk("t1_done", {29'b0, done, busy, triggered}, 3'b101);
        chk("t1_trig_addr", {28'b0, trig_addr}, 8);
        chk("t1_start_addr", {28'b0, start_addr}, 4);
        chk("t1_we_count", n_we, 20);
        for (int i = 0; i < DEP; i++)
            chk("t1_record", mem[(4 + i) % DEP], -4 + i);
        send(12);

        // 2: decimation by 4, re-arm from DONE; arm while busy ignored
        cfg(3, 4, 1, 1000);
        do_arm();
        n_we = 0;
        for (int i = 0; i < 40; i++) begin
            send(0);
            if (i == 10) do_arm();
        end
        chk("t2_we_count", n_we, 10);
        chk("t2_busy", {30'b0, busy, triggered}, 2'b10);
        do_abort();

        // 3: falling trigger after the buffer wraps three times
        cfg(0, 4, 0, 100);
        do_arm();
        for (int i = 0; i < 3 * DEP; i++) send(200);
        chk("t3_no_trig", {31'b0, triggered}, 0);
        send(50);
        chk("t3_triggered", {31'b0, triggered}, 1);
        chk("t3_trig_addr", {28'b0, trig_addr}, 0);
        chk("t3_start_addr", {28'b0, start_addr}, 12);
        for (int i = 0; i < 11; i++) send(50);
        chk("t3_done", {31'b0, done}, 1);

        // 4: force ignored in FILL, honoured in WAIT_TRIG on a flat signal
        cfg(0, 4, 1, 1000);
        do_arm();
        send(0, 1);
        for (int i = 0; i < 5; i++) send(0);
        chk("t4_not_trig", {31'b0, triggered}, 0);
        force_only();
        chk("t4_pending", {31'b0, triggered}, 0);
        send(0);
        chk("t4_triggered", {31'b0, triggered}, 1);
        chk("t4_trig_addr", {28'b0, trig_addr}, 6);
        chk("t4_start_addr", {28'b0, start_addr}, 2);

        // 5: abort mid-POST
        for (int i = 0; i < 3; i++) send(0);
        do_abort();
        chk("t5_idle", {29'b0, busy, done, triggered}, 0);
        send(0); send(0);

        // 6: maximum pretrig leaves no post-trigger writes
        cfg(0, DEP - 1, 1, 10);
        do_arm();
        for (int i = 0; i < DEP - 1; i++) send(0);
        chk("t6_wait", {30'b0, busy, triggered}, 2'b10);
        send(20);
        chk("t6_done", {29'b0, done, busy, triggered}, 3'b101);
        chk("t6_trig_addr", {28'b0, trig_addr}, DEP - 1);
        chk("t6_start_addr", {28'b0, start_addr}, 0);
        send(20);

        // reset asserted mid-FILL, checked before any clock edge
        cfg(0, 4, 1, 0);
        do_arm();
        send(5); send(6);
        #2 rst = 1;
        #1 chk_outs_zero("rst_async");
        m_st = M_IDLE;
        @(negedge clk);
        send(7);
        rst = 0;
        @(negedge clk);
        send(8);
        chk("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
